// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue
// ----------------
// Dual-issue fetch front end. Each cycle it may issue one paired read of the
// PC pair held in the external PC register, and it advances that register by 8.
// The returned {PC0, PC1, IR0, IR1} bundle is buffered in a DEPTH-entry FIFO for
// decode. A redirect flushes the FIFO, drops any read still in flight, and loads
// the word-aligned target into the PC register.
//
// Ports
//   FQ_CLK, FQ_RSTN            clock, synchronous active-low reset
//   FQ_PC0, FQ_PC1             current PC pair from the PC register
//   FQ_PC_LD, FQ_NPC0/1        load enable and next PC pair to the PC register
//   FQ_REDIRECT, FQ_TARGET     flush/redirect request and its target
//   FQ_IMEM_RD                 paired read request for FQ_PC0/FQ_PC1
//   FQ_IMEM_VALID, FQ_IR0/1    read data, one cycle after FQ_IMEM_RD
//   FQ_DEQ_VALID/READY         head bundle handshake with decode
//   FQ_DEQ_PC0/1, FQ_DEQ_IR0/1 head bundle
//   FQ_COUNT                   occupied FIFO entries
module fetch_pair_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     FQ_CLK,
    input  logic                     FQ_RSTN,
    input  logic [31:0]              FQ_PC0,
    input  logic [31:0]              FQ_PC1,
    output logic                     FQ_PC_LD,
    output logic [31:0]              FQ_NPC0,
    output logic [31:0]              FQ_NPC1,
    input  logic                     FQ_REDIRECT,
    input  logic [31:0]              FQ_TARGET,
    output logic                     FQ_IMEM_RD,
    input  logic                     FQ_IMEM_VALID,
    input  logic [31:0]              FQ_IR0,
    input  logic [31:0]              FQ_IR1,
    output logic                     FQ_DEQ_VALID,
    input  logic                     FQ_DEQ_READY,
    output logic [31:0]              FQ_DEQ_PC0,
    output logic [31:0]              FQ_DEQ_PC1,
    output logic [31:0]              FQ_DEQ_IR0,
    output logic [31:0]              FQ_DEQ_IR1,
    output logic [$clog2(DEPTH):0]   FQ_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);

    // FIFO storage, packed as {pc0, pc1, ir0, ir1}
    logic [127:0]  store_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Read in flight: valid, discard-on-return, and the PC pair it was issued for
    logic          inf_v_r;
    logic          inf_d_r;
    logic [31:0]   inf_pc0_r;
    logic [31:0]   inf_pc1_r;

    logic [CW:0]   occ_s;
    logic          issue_s;
    logic          ret_s;
    logic          enq_s;
    logic          deq_s;
    logic [31:0]   tgt_s;
    logic [127:0]  head_s;
    logic          pc_ld_s;
    logic [31:0]   npc0_s;
    logic [31:0]   npc1_s;

    // Credit counts the in-flight read as occupied so its return always finds
    // a free slot; a dequeue in the same cycle deliberately gives no credit.
    assign occ_s   = {1'b0, count_r} + {{CW{1'b0}}, inf_v_r};
    assign issue_s = FQ_RSTN & ~FQ_REDIRECT & (occ_s < DEPTH_L);
    assign ret_s   = FQ_IMEM_VALID & inf_v_r;
    assign enq_s   = ret_s & ~inf_d_r & ~FQ_REDIRECT;
    assign deq_s   = (count_r != {CW{1'b0}}) & FQ_DEQ_READY & ~FQ_REDIRECT;
    // Target low bits are forced to zero (word-aligned pair)
    assign tgt_s   = FQ_TARGET & 32'hFFFF_FFFC;
    assign head_s  = store_r[rd_ptr_r];

    // Next-PC selection: redirect wins over sequential advance; quiet in reset
    always_comb begin
        pc_ld_s = 1'b0;
        npc0_s  = 32'd0;
        npc1_s  = 32'd0;
        if (!FQ_RSTN) begin
            pc_ld_s = 1'b0;
        end else if (FQ_REDIRECT) begin
            pc_ld_s = 1'b1;
            npc0_s  = tgt_s;
            npc1_s  = tgt_s + 32'd4;
        end else begin
            pc_ld_s = issue_s;
            npc0_s  = FQ_PC0 + 32'd8;
            npc1_s  = FQ_PC1 + 32'd8;
        end
    end

    assign FQ_PC_LD     = pc_ld_s;
    assign FQ_NPC0      = npc0_s;
    assign FQ_NPC1      = npc1_s;
    assign FQ_IMEM_RD   = issue_s;
    assign FQ_DEQ_VALID = FQ_RSTN & (count_r != {CW{1'b0}});
    assign FQ_COUNT     = FQ_RSTN ? count_r : {CW{1'b0}};
    assign FQ_DEQ_PC0   = FQ_RSTN ? head_s[127:96] : 32'd0;
    assign FQ_DEQ_PC1   = FQ_RSTN ? head_s[95:64]  : 32'd0;
    assign FQ_DEQ_IR0   = FQ_RSTN ? head_s[63:32]  : 32'd0;
    assign FQ_DEQ_IR1   = FQ_RSTN ? head_s[31:0]   : 32'd0;

    // Pointer, occupancy and in-flight bookkeeping
    always_ff @(posedge FQ_CLK) begin
        if (!FQ_RSTN) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            inf_v_r   <= 1'b0;
            inf_d_r   <= 1'b0;
            inf_pc0_r <= 32'd0;
            inf_pc1_r <= 32'd0;
        end else begin
            if (FQ_REDIRECT) begin
                // A handshake in this cycle is not delivered; empty everything
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                count_r  <= {CW{1'b0}};
            end else begin
                if (enq_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (deq_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                case ({enq_s, deq_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end

            if (issue_s) begin
                inf_v_r   <= 1'b1;
                inf_d_r   <= 1'b0;
                inf_pc0_r <= FQ_PC0;
                inf_pc1_r <= FQ_PC1;
            end else begin
                // A return retires the slot; a redirect poisons whatever is left
                inf_v_r <= inf_v_r & ~FQ_IMEM_VALID;
                inf_d_r <= inf_d_r | FQ_REDIRECT;
            end
        end
    end

    // Bundle capture into the slot at the write pointer
    always_ff @(posedge FQ_CLK) begin
        if (FQ_RSTN && enq_s) begin
            store_r[wr_ptr_r] <= {inf_pc0_r, inf_pc1_r, FQ_IR0, FQ_IR1};
        end
    end

endmodule

// File: doc/fetch_pair_queue.md
# fetch_pair_queue

Dual-issue instruction fetch front end that consumes the PC pair held in the PC register, issues paired instruction-memory reads, and buffers the returned {PC0, PC1, IR0, IR1} bundles in a DEPTH-entry FIFO for decode. It produces the PC register's load enable and next-PC pair: sequential advance by 8, or a redirect target on branch or flush. It sits between the PC register, instruction memory and decode in the OOO pipeline.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- FQ_CLK  in  1  clock; all state updates on posedge
- FQ_RSTN  in  1  synchronous, active-low reset
- FQ_PC0, FQ_PC1  in  32  current PC pair from PC register (PC1 = PC0+4)
- FQ_PC_LD  out  1  load enable to PC register
- FQ_NPC0, FQ_NPC1  out  32  next PC pair to PC register
- FQ_REDIRECT  in  1  flush and redirect request (single-cycle pulse or level)
- FQ_TARGET  in  32  redirect target; bits [1:0] ignored (treated as 0)
- FQ_IMEM_RD  out  1  read request for FQ_PC0/FQ_PC1 this cycle
- FQ_IMEM_VALID  in  1  read data valid, exactly 1 cycle after FQ_IMEM_RD
- FQ_IR0, FQ_IR1  in  32  instruction words for PC0/PC1
- FQ_DEQ_VALID  out  1  head bundle valid
- FQ_DEQ_READY  in  1  decode accepts head bundle
- FQ_DEQ_PC0, FQ_DEQ_PC1, FQ_DEQ_IR0, FQ_DEQ_IR1  out  32 each  head bundle
- FQ_COUNT  out  clog2(DEPTH)+1  occupied entries

## Operation
- State: FIFO storage, rd/wr pointers, registered count, inflight register {valid, discard, pc0, pc1}.
- Issue: FQ_IMEM_RD = FQ_RSTN & !FQ_REDIRECT & (count + inflight.valid < DEPTH). Uses registered count only; a same-cycle dequeue gives no credit.
- On issue: inflight <= {1, 0, FQ_PC0, FQ_PC1}; FQ_PC_LD = 1; FQ_NPC0/1 = FQ_PC0+8 / FQ_PC1+8. Addition is mod 2^32.
- Return: with FQ_IMEM_VALID and inflight.valid & !inflight.discard, enqueue {inflight.pc0, inflight.pc1, FQ_IR0, FQ_IR1}. Inflight clears unless a new issue reloads it the same cycle.
- FQ_IMEM_VALID with no valid inflight entry: ignored.
- Dequeue: fires on FQ_DEQ_VALID & FQ_DEQ_READY. FQ_DEQ_VALID = (count != 0). Head outputs come from registered storage.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance, wrapping mod DEPTH.
- Enqueue while full cannot occur, because the credit check forbids it. A bench checker flags it as an error.
- Redirect (highest priority):
  - FIFO is emptied (pointers and count reset).
  - Any inflight entry is marked discard; its return is dropped.
  - FQ_PC_LD = 1; FQ_NPC0 = {FQ_TARGET[31:2], 2'b00}, FQ_NPC1 = FQ_NPC0+4.
  - No issue in the redirect cycle.
  - A dequeue handshake in the redirect cycle is not counted as delivered; decode must ignore it.
- No issue and no redirect: FQ_PC_LD = 0; FQ_NPC0/1 = FQ_PC0+8 / FQ_PC1+8 (don't-care).

## Timing
- Reset (FQ_RSTN = 0 at posedge): count = 0, pointers = 0, inflight cleared. During reset FQ_PC_LD, FQ_IMEM_RD and FQ_DEQ_VALID are 0 and FQ_COUNT = 0. Reset overrides redirect, return and dequeue in the same cycle.
- Reset mid-operation: the pending return arriving in the cycle after reset release is dropped (inflight already cleared).
- Fetch-to-dequeue latency: issue at cycle N, enqueue at edge N+1, FQ_DEQ_VALID high in cycle N+2.
- Steady-state throughput with decode always ready: one bundle per cycle. Issue continues while count + inflight < DEPTH.
- Backpressure: with decode stalled, issue stops once count + inflight = DEPTH. The final return fills the FIFO exactly.
- First issue after redirect is the cycle after redirect, at the target PC now loaded in the PC register.

## Test plan
- Reset then PC pair 0x0/0x4, FQ_DEQ_READY = 1, memory returns IR = PC ^ 0xA5A5A5A5 -> bundles at PCs 0x0, 0x8, 0x10, … in order, one per cycle from cycle 2. FQ_NPC tracks PC+8.
- FQ_DEQ_READY = 0 from reset, DEPTH = 4 -> exactly 4 issues. FQ_COUNT reaches 4. FQ_IMEM_RD stays 0 while full. Asserting ready resumes issue the cycle after the first dequeue is registered.
- Redirect to 0x1003 with 3 entries queued and one read inflight -> FQ_NPC0 = 0x1000, FQ_NPC1 = 0x1004, FQ_PC_LD = 1. FQ_COUNT = 0 next cycle. Stale return dropped. Next bundle PC0 = 0x1000.
- PC0 = 0xFFFFFFF8 -> FQ_NPC0 = 0x00000000, FQ_NPC1 = 0x00000004. Bundle order preserved across wrap of FIFO pointers after DEPTH+3 bundles.
- Redirect and FQ_DEQ_READY in the same cycle with count = 1 -> FQ_COUNT = 0, no double pop, pointers consistent on the following enqueue.
- FQ_RSTN low for one cycle while a read is inflight -> all outputs 0 during reset. The return the next cycle is ignored. FQ_COUNT stays 0 until a fresh issue.
